apb_slave_mem: RTL and testbench
================================

APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256, meaning number of 32-bit words of storage (power of two, 4..4096).
REQ-002 SHALL have parameter WAIT_STATES, default 2, meaning number of ACCESS cycles with PREADY low before completion (0..15).
REQ-003 SHALL have port PCLK, input, 1, the single clock; all logic samples on rising edge.
REQ-004 SHALL have port PRESET, input, 1, reset; asynchronous assert, active-high.
REQ-005 SHALL have port PSEL, input, 1, slave select.
REQ-006 SHALL have port PENABLE, input, 1, ACCESS-phase indicator.
REQ-007 SHALL have port PWRITE, input, 1, 1 = write, 0 = read.
REQ-008 SHALL have port PADDR, input, 32, byte address.
REQ-009 SHALL have port PWDATA, input, 32, write data.
REQ-010 SHALL have port PSTRB, input, 4, byte-lane write enables.
REQ-011 SHALL have port PPROT, input, 3, protection attributes; accepted and ignored.
REQ-012 SHALL have port PRDATA, output, 32, read data, valid when PREADY is high.
REQ-013 SHALL have port PREADY, output, 1, transfer completion.
REQ-014 SHALL have port PSLVERR, output, 1, transfer error, valid when PREADY is high.

Function
REQ-015 SHALL implement FSM states IDLE and ACCESS, with the wait count held in a 4-bit down-counter.
REQ-016 IDLE->ACCESS SHALL occur on an edge sampling PSEL=1 and PENABLE=0 (SETUP), and that edge SHALL capture PADDR, PWRITE, PWDATA and PSTRB and load the counter with WAIT_STATES.
REQ-017 In ACCESS, a sample of PSEL=1, PENABLE=1 with counter > 0 SHALL decrement the counter.
REQ-018 PREADY SHALL equal (state==ACCESS && counter==0), decoded from registers only, with no combinational input-to-output path.
REQ-019 The completion edge (ACCESS, PENABLE=1, PREADY=1) SHALL return the FSM to IDLE; a SETUP on the following cycle SHALL then be accepted normally.
REQ-020 The error condition SHALL be PADDR[1:0]!=0 or word index PADDR[31:2] >= MEM_DEPTH, evaluated on the captured address.
REQ-021 PSLVERR SHALL be high exactly when PREADY is high and the captured access is in error, and SHALL be low otherwise.
REQ-022 A read SHALL load PRDATA from storage at the SETUP edge, and PRDATA SHALL hold until the next SETUP.
REQ-023 PRDATA SHALL be 0 for writes and for erroring reads.
REQ-024 A write SHALL update storage only on the completion edge and only if there is no error; no update SHALL occur otherwise.
REQ-025 If the FSM is in ACCESS and samples PSEL=0 or PENABLE=0 (protocol violation), it SHALL return to IDLE with no write, and if PSEL=1 and PENABLE=0 it SHALL treat that edge as a new SETUP.
REQ-026 With WAIT_STATES=0, PREADY SHALL be high in the first ACCESS cycle, giving zero wait states.
REQ-027 Back-to-back transfers to the same word SHALL read the value committed by the preceding write.

Reset
REQ-028 PRESET high SHALL immediately force state=IDLE, counter=0, PREADY=0, PSLVERR=0 and PRDATA=0, including in the middle of a transfer.
REQ-029 A write aborted by reset SHALL NOT modify storage, and storage contents SHALL NOT be reset.

Configuration
REQ-030 With macro APB_SLAVE_PSTRB_EN defined, a write SHALL update only the byte lanes whose PSTRB bit is 1, and PSTRB=0000 SHALL complete without error and change nothing.
REQ-031 With APB_SLAVE_PSTRB_EN undefined, PSTRB SHALL be ignored and every non-error write SHALL update all 4 bytes.

Structure
REQ-032 Package apb_slave_pkg SHALL hold the FSM state enum (IDLE, ACCESS), APB_DATA_W=32, APB_STRB_W=4, and the error-decode function.
REQ-033 Storage SHALL be a sub-module apb_slave_mem_array with a synchronous byte-enabled write, a read port used at SETUP, and parameter MEM_DEPTH.

Verification
REQ-034 The bench SHALL cover: write 0xDEADBEEF to 0x10 with PSTRB=1111, WAIT_STATES=2 -> PREADY high on the 3rd ACCESS cycle, PSLVERR=0; a subsequent read of 0x10 -> PRDATA=0xDEADBEEF.
REQ-035 The bench SHALL cover: with APB_SLAVE_PSTRB_EN, write 0x11223344 to 0x10 (word holding 0xDEADBEEF) with PSTRB=0011 -> read 0xDEAD3344; without the macro -> read 0x11223344.
REQ-036 The bench SHALL cover: read 0x400 with MEM_DEPTH=256 -> PSLVERR=1 and PRDATA=0 at PREADY; write 0x12 -> PSLVERR=1 and storage unchanged.
REQ-037 The bench SHALL cover: with WAIT_STATES=0, back-to-back write then read of 0x20 with no idle cycle -> each transfer completes in 2 cycles, and the read returns the written data.
REQ-038 The bench SHALL cover: PRESET pulsed during ACCESS of a write of 0xCAFEF00D to 0x30 -> PREADY=0 immediately, and a later read of 0x30 returns the old value.
REQ-039 The bench SHALL cover: PSEL dropped in ACCESS cycle 1 of a write -> FSM returns to IDLE, no PREADY pulse, and storage unchanged.

Source files
------------

// File: rtl/apb_slave_pkg.sv
// Shared types, widths and the address-error decode for the APB slave memory.
package apb_slave_pkg;

  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  // An access errors when the byte address is not word aligned or the word
  // index falls outside the implemented storage.
  function automatic logic apb_addr_err(input logic [31:0] addr,
                                        input logic [31:0] depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB bus signals between a master and the memory slave.
interface apb_slave_mem_if;
  import apb_slave_pkg::*;

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [31:0]           PADDR;
  logic [APB_DATA_W-1:0] PWDATA;
  logic [APB_STRB_W-1:0] PSTRB;
  logic [2:0]            PPROT;
  logic [APB_DATA_W-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_slave_mem_array.sv
// Word storage with a synchronous byte-enabled write port and an
// asynchronous read port. Contents are deliberately not reset.
module apb_slave_mem_array
  import apb_slave_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int AW        = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [APB_STRB_W-1:0] wbe,
  input  logic [AW-1:0]         waddr,
  input  logic [APB_DATA_W-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [APB_DATA_W-1:0] rdata
);

  logic [APB_DATA_W-1:0] mem [MEM_DEPTH];

  // Commit enabled byte lanes on the write edge.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < APB_STRB_W; b++) begin
        if (wbe[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB slave memory with programmable wait states and address-error response.
// Optional feature macro: APB_SLAVE_PSTRB_EN (byte-lane write strobes honoured;
// when undefined every successful write updates the full word).
module apb_slave_mem
  import apb_slave_pkg::*;
#(
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 2
) (
  input logic            PCLK,
  input logic            PRESET,
  apb_slave_mem_if.slave bus
);

  localparam int AW = $clog2(MEM_DEPTH);

  apb_state_e            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [AW-1:0]         widx_q, widx_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [APB_DATA_W-1:0] wdata_q, wdata_d;
  logic [APB_STRB_W-1:0] strb_q, strb_d;
  logic [APB_DATA_W-1:0] prdata_q, prdata_d;

  logic                  setup, access, capture, in_err, mem_we, pready;
  logic [APB_STRB_W-1:0] wbe;
  logic [APB_DATA_W-1:0] mem_rdata;
  logic                  prot_unused;

  assign setup       = bus.PSEL & ~bus.PENABLE;
  assign access      = bus.PSEL & bus.PENABLE;
  assign in_err      = apb_addr_err(bus.PADDR, 32'(MEM_DEPTH));
  assign prot_unused = ^bus.PPROT;

  // Next-state decode: SETUP captures the request, ACCESS counts down the
  // wait states and commits a write on the completion edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    widx_d   = widx_q;
    write_d  = write_q;
    err_d    = err_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    prdata_d = prdata_q;
    mem_we   = 1'b0;
    capture  = 1'b0;

    case (state_q)
      IDLE: begin
        if (setup) capture = 1'b1;
      end
      ACCESS: begin
        if (access) begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = IDLE;
            mem_we  = write_q & ~err_q;
          end
        end else if (setup) begin
          // Protocol violation that looks like a fresh SETUP: restart.
          capture = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    if (capture) begin
      state_d  = ACCESS;
      cnt_d    = 4'(WAIT_STATES);
      widx_d   = bus.PADDR[AW+1:2];
      write_d  = bus.PWRITE;
      err_d    = in_err;
      wdata_d  = bus.PWDATA;
      strb_d   = bus.PSTRB;
      prdata_d = (!bus.PWRITE && !in_err) ? mem_rdata : '0;
    end
  end

  // State and request registers, cleared asynchronously.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      widx_q   <= '0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      widx_q   <= widx_d;
      write_q  <= write_d;
      err_q    <= err_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      prdata_q <= prdata_d;
    end
  end

`ifdef APB_SLAVE_PSTRB_EN
  assign wbe = strb_q;
`else
  logic strb_unused;
  assign strb_unused = ^strb_q;
  assign wbe         = '1;
`endif

  apb_slave_mem_array #(
    .MEM_DEPTH(MEM_DEPTH),
    .AW       (AW)
  ) u_array (
    .clk  (PCLK),
    .we   (mem_we),
    .wbe  (wbe),
    .waddr(widx_q),
    .wdata(wdata_q),
    .raddr(bus.PADDR[AW+1:2]),
    .rdata(mem_rdata)
  );

  // Outputs decode from registers only.
  assign pready      = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign bus.PREADY  = pready;
  assign bus.PSLVERR = pready & err_q;
  assign bus.PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: two instances (2 and 0 wait states) driven by
// directed and random APB transfers against a word-level reference model.
module tb_apb_slave_mem;

  localparam int DEPTH = 256;
  localparam int WS0   = 2;
  localparam int WS1   = 0;
`ifdef APB_SLAVE_PSTRB_EN
  localparam bit PSTRB_EN = 1'b1;
`else
  localparam bit PSTRB_EN = 1'b0;
`endif

  logic PCLK = 1'b0;
  logic PRESET;
  always #5 PCLK = ~PCLK;

  logic [1:0]       psel, penable, pwrite;
  logic [1:0][31:0] paddr, pwdata;
  logic [1:0][3:0]  pstrb;
  logic [1:0][2:0]  pprot;

  apb_slave_mem_if if0 ();
  apb_slave_mem_if if1 ();

  assign if0.PSEL = psel[0];    assign if1.PSEL = psel[1];
  assign if0.PENABLE = penable[0]; assign if1.PENABLE = penable[1];
  assign if0.PWRITE = pwrite[0]; assign if1.PWRITE = pwrite[1];
  assign if0.PADDR = paddr[0];  assign if1.PADDR = paddr[1];
  assign if0.PWDATA = pwdata[0]; assign if1.PWDATA = pwdata[1];
  assign if0.PSTRB = pstrb[0];  assign if1.PSTRB = pstrb[1];
  assign if0.PPROT = pprot[0];  assign if1.PPROT = pprot[1];

  wire [1:0]       pready  = {if1.PREADY, if0.PREADY};
  wire [1:0]       pslverr = {if1.PSLVERR, if0.PSLVERR};
  wire [1:0][31:0] prdata  = {if1.PRDATA, if0.PRDATA};

  apb_slave_mem #(.MEM_DEPTH(DEPTH), .WAIT_STATES(WS0)) dut0 (
    .PCLK(PCLK), .PRESET(PRESET), .bus(if0.slave));
  apb_slave_mem #(.MEM_DEPTH(DEPTH), .WAIT_STATES(WS1)) dut1 (
    .PCLK(PCLK), .PRESET(PRESET), .bus(if1.slave));

  int n_cmp = 0;
  int n_mis = 0;
  bit [31:0] mdl [int];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] st);
    logic [3:0] eff = PSTRB_EN ? st : 4'hF;
    for (int b = 0; b < 4; b++) if (eff[b]) old[8*b +: 8] = nw[8*b +: 8];
    return old;
  endfunction

  task automatic idle(input int d);
    @(negedge PCLK);
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  // One complete transfer; returns data/error sampled when PREADY is high and
  // the number of ACCESS cycles spent.
  task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] st, output logic [31:0] rd, output logic err,
                      output int cyc);
    @(negedge PCLK);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a;
    pwdata[d] = wd; pstrb[d] = st; pprot[d] = 3'($urandom);
    @(posedge PCLK);
    @(negedge PCLK);
    penable[d] = 1'b1;
    cyc = 1;
    while (pready[d] !== 1'b1 && cyc < 40) begin
      @(posedge PCLK);
      @(negedge PCLK);
      cyc++;
    end
    rd  = prdata[d];
    err = pslverr[d];
    @(posedge PCLK);
  endtask

  task automatic xfer_chk(input int d, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] st, input string tag,
                          output logic [31:0] rd);
    bit        bad = addr_bad(a);
    int        key = 0;
    bit        known = 1'b1;
    logic [31:0] exp_rd = 32'h0;
    logic      err;
    int        cyc;
    if (!bad) key = d * 65536 + int'(a[31:2]);
    if (!wr && !bad) begin
      known  = mdl.exists(key);
      exp_rd = known ? mdl[key] : 32'h0;
    end
    xfer(d, wr, a, wd, st, rd, err, cyc);
    check({tag, "_cycles"}, 32'(cyc), 32'((d == 0 ? WS0 : WS1) + 1));
    check({tag, "_slverr"}, 32'(err), 32'(bad));
    if (known) check({tag, "_prdata"}, rd, exp_rd);
    if (wr && !bad) mdl[key] = merge(mdl.exists(key) ? mdl[key] : 32'h0, wd, st);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    int          n;
    bit          saw;
    psel = '0; penable = '0; pwrite = '0; paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    PRESET = 1'b1;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    for (int d = 0; d < 2; d++) begin
      check("rst_pready", 32'(pready[d]), 32'h0);
      check("rst_pslverr", 32'(pslverr[d]), 32'h0);
      check("rst_prdata", prdata[d], 32'h0);
    end
    PRESET = 1'b0;

    // Known contents for the low words of both instances (full-strobe writes).
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 20; w++) xfer_chk(d, 1'b1, 32'(w * 4), $urandom, 4'hF, "fill", rd);

    // Basic write/read with two wait states.
    xfer_chk(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "wr10", rd);
    idle(0);
    xfer_chk(0, 1'b0, 32'h10, 32'h0, 4'hF, "rd10", rd);
    check("rd10_const", rd, 32'hDEADBEEF);

    // Partial-strobe write.
    xfer_chk(0, 1'b1, 32'h10, 32'h11223344, 4'b0011, "wrstrb", rd);
    xfer_chk(0, 1'b0, 32'h10, 32'h0, 4'hF, "rdstrb", rd);
    check("strb_merge", rd, PSTRB_EN ? 32'hDEAD3344 : 32'h11223344);
    xfer_chk(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, "wrstrb0", rd);
    xfer_chk(0, 1'b0, 32'h10, 32'h0, 4'hF, "rdstrb0", rd);

    // Error responses: out of range read, misaligned write.
    xfer_chk(0, 1'b0, 32'h400, 32'h0, 4'hF, "rd400", rd);
    xfer_chk(0, 1'b1, 32'h12, 32'hA5A5A5A5, 4'hF, "wr12", rd);
    xfer_chk(0, 1'b0, 32'h10, 32'h0, 4'hF, "rd10_after_err", rd);

    // Zero wait states, back-to-back write then read.
    xfer_chk(1, 1'b1, 32'h20, 32'h13572468, 4'hF, "b2b_wr", rd);
    xfer_chk(1, 1'b0, 32'h20, 32'h0, 4'hF, "b2b_rd", rd);
    check("b2b_const", rd, 32'h13572468);
    idle(1);

    // Reset while a write sits at its completion cycle.
    idle(0);
    @(negedge PCLK);
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h30;
    pwdata[0] = 32'hCAFEF00D; pstrb[0] = 4'hF;
    @(posedge PCLK);
    @(negedge PCLK);
    penable[0] = 1'b1;
    n = 0;
    while (pready[0] !== 1'b1 && n < 20) begin @(posedge PCLK); @(negedge PCLK); n++; end
    check("rst_mid_before", 32'(pready[0]), 32'h1);
    PRESET = 1'b1;
    #1;
    check("rst_mid_pready", 32'(pready[0]), 32'h0);
    check("rst_mid_pslverr", 32'(pslverr[0]), 32'h0);
    check("rst_mid_prdata", prdata[0], 32'h0);
    @(negedge PCLK);
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(negedge PCLK);
    PRESET = 1'b0;
    xfer_chk(0, 1'b0, 32'h30, 32'h0, 4'hF, "rd30_after_rst", rd);

    // PSEL dropped in the first ACCESS cycle of a write.
    idle(0);
    @(negedge PCLK);
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 32'h40;
    pwdata[0] = 32'h55AA55AA; pstrb[0] = 4'hF;
    @(posedge PCLK);
    @(negedge PCLK);
    psel[0] = 1'b0; penable[0] = 1'b0;
    saw = 1'b0;
    repeat (6) begin
      @(posedge PCLK);
      @(negedge PCLK);
      if (pready[0] === 1'b1) saw = 1'b1;
    end
    check("viol_no_pready", 32'(saw), 32'h0);
    xfer_chk(0, 1'b0, 32'h40, 32'h0, 4'hF, "rd40_after_viol", rd);

    // Random traffic on both instances.
    for (int i = 0; i < 80; i++) begin
      int          d = int'($urandom_range(0, 1));
      int          r = int'($urandom_range(0, 9));
      logic [31:0] a;
      if (r == 0)      a = {24'h0, 4'($urandom_range(0, 15)), 2'b00, 2'($urandom_range(1, 3))};
      else if (r == 1) a = 32'h400 + 32'($urandom_range(0, 63)) * 4;
      else             a = 32'($urandom_range(0, 19)) * 4;
      xfer_chk(d, 1'($urandom), a, $urandom, 4'($urandom), "rnd", rd);
      if ($urandom_range(0, 3) == 0) idle(d);
    end

    idle(0);
    idle(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
